reg_writeback_unit: RTL

Writeback-side driver of the pipeline register file write port. Accepts ALU results from execute and load data returning from data memory, and arbitrates them onto the single write port (wrtEn/wrtIndex/dataIn/fstOpcode). Tracks in-flight load destinations in a pending-load FIFO and per-register scoreboard. Raises a stall to decode on load-use hazards, because the register file never forwards load data.

---
 rtl/reg_writeback_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: drives the register file write port from ALU results and returning loads, tracks in-flight loads (optional WB_ERR_STATUS_EN enables sticky error flags)
module reg_writeback_unit #(
   parameter int INDEX_BIT_WIDTH = 4,
   parameter int DATA_BIT_WIDTH = 32,
   parameter int N_REGS = 1 << INDEX_BIT_WIDTH,
   parameter logic [3:0] OP1_LW = 4'b1001,
   parameter int LD_QUEUE_DEPTH = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic exValid,
   input  logic exWrtReg,
   input  logic [3:0] exOpcode,
   input  logic [INDEX_BIT_WIDTH-1:0] exDstIndex,
   input  logic [DATA_BIT_WIDTH-1:0] exData,
   input  logic memRdValid,
   input  logic [DATA_BIT_WIDTH-1:0] memRdData,
   input  logic [INDEX_BIT_WIDTH-1:0] rdIndex1,
   input  logic [INDEX_BIT_WIDTH-1:0] rdIndex2,
   output logic wrtEn,
   output logic [INDEX_BIT_WIDTH-1:0] wrtIndex,
   output logic [3:0] fstOpcode,
   output logic [DATA_BIT_WIDTH-1:0] dataIn,
   output logic stall,
   output logic loadPending,
   output logic errOverflow,
   output logic errUnderflow
);
   localparam int PW = $clog2(LD_QUEUE_DEPTH);
   localparam int CW = $clog2(LD_QUEUE_DEPTH + 1);
   localparam logic [PW:0] PTR_ONE = 1;

   logic [INDEX_BIT_WIDTH-1:0] ldFifo [LD_QUEUE_DEPTH];
   logic [PW:0] wrPtr, rdPtr;
   logic [CW-1:0] sb [N_REGS];
   logic skidValid;
   logic [INDEX_BIT_WIDTH-1:0] skidIndex;
   logic [DATA_BIT_WIDTH-1:0] skidData;
   logic [3:0] skidOpcode;
   logic aluWr, ldIssue, fifoEmpty, fifoFull, pop, push;
   logic [INDEX_BIT_WIDTH-1:0] head;

   // decode requests, FIFO status and the load-use / structural stall
   always_comb begin
      aluWr = exValid & exWrtReg & (exOpcode != OP1_LW);
      ldIssue = exValid & exWrtReg & (exOpcode == OP1_LW);
      fifoEmpty = wrPtr == rdPtr;
      fifoFull = (wrPtr[PW] != rdPtr[PW]) && (wrPtr[PW-1:0] == rdPtr[PW-1:0]);
      pop = memRdValid & ~fifoEmpty;
      push = ldIssue & (~fifoFull | pop);
      head = ldFifo[rdPtr[PW-1:0]];
      stall = (sb[rdIndex1] != '0) | (sb[rdIndex2] != '0) | fifoFull | skidValid;
   end

   assign loadPending = ~fifoEmpty;

   // pending-load destination storage; validity is tracked by the pointers
   always_ff @(posedge clk)
      if (push) ldFifo[wrPtr[PW-1:0]] <= exDstIndex;

   // pointers, scoreboard, skid and the write port (load return > skid > ALU)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         for (int i = 0; i < N_REGS; i++) sb[i] <= '0;
         skidValid <= 1'b0;
         skidIndex <= '0;
         skidData <= '0;
         skidOpcode <= '0;
         wrtEn <= 1'b0;
         wrtIndex <= '0;
         fstOpcode <= '0;
         dataIn <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + PTR_ONE;
         if (pop) rdPtr <= rdPtr + PTR_ONE;
         for (int i = 0; i < N_REGS; i++)
            sb[i] <= sb[i] + CW'(push && exDstIndex == INDEX_BIT_WIDTH'(i)) - CW'(pop && head == INDEX_BIT_WIDTH'(i));
         wrtEn <= pop | skidValid | aluWr;
         if (pop) begin
            wrtIndex <= head;
            dataIn <= memRdData;
            fstOpcode <= OP1_LW;
         end else if (skidValid) begin
            wrtIndex <= skidIndex;
            dataIn <= skidData;
            fstOpcode <= skidOpcode;
         end else if (aluWr) begin
            wrtIndex <= exDstIndex;
            dataIn <= exData;
            fstOpcode <= exOpcode;
         end
         if (aluWr && (pop || skidValid)) begin
            skidValid <= 1'b1;
            skidIndex <= exDstIndex;
            skidData <= exData;
            skidOpcode <= exOpcode;
         end else if (!pop) skidValid <= 1'b0;
      end
   end

`ifdef WB_ERR_STATUS_EN
   // sticky overflow/underflow flags, cleared only by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         errOverflow <= 1'b0;
         errUnderflow <= 1'b0;
      end else begin
         if (ldIssue & fifoFull & ~pop) errOverflow <= 1'b1;
         if (memRdValid & fifoEmpty) errUnderflow <= 1'b1;
      end
   end
`else
   assign errOverflow = 1'b0;
   assign errUnderflow = 1'b0;
`endif
endmodule
